// File: rtl/sid_mixer_pkg.sv
// Shared types and constants for the SID mixer: FSM state encoding, widths,
// filter-route bit positions and the 6581 direct-path bias.
package sid_pkg;

    typedef enum logic [3:0] {
        IDLE,
        S1,
        S2,
        S3,
        S4,
        OFFER,
        WAIT_FILT,
        MIX,
        V0,
        V1,
        V2,
        V3,
        DONE
    } mix_state_t;

    localparam int SUM_W = 16;
    localparam int OUT_W = 21;

    localparam int ROUTE_V1  = 0;
    localparam int ROUTE_V2  = 1;
    localparam int ROUTE_V3  = 2;
    localparam int ROUTE_EXT = 3;

    localparam logic signed [15:0] DC_6581 = 16'sd1024;

endpackage

// File: rtl/sid_mixer_vmul.sv
// Four-step serial shift-add volume multiplier: i_start latches the mix,
// then one volume bit is consumed per clock; o_done pulses with the product.
module sid_mixer_vmul #(
    parameter int MIX_W = 17,
    parameter int OUT_W = 21
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_start,
    input  logic signed [MIX_W-1:0] i_mix,
    input  logic [3:0]              i_vol,
    output logic signed [OUT_W-1:0] o_prod,
    output logic                    o_done
);

    logic                    r_busy;
    logic [1:0]              r_step;
    logic signed [OUT_W-1:0] r_mix;
    logic signed [OUT_W-1:0] r_prod;
    logic                    r_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_step <= '0;
            r_mix  <= '0;
            r_prod <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_mix  <= OUT_W'(i_mix);
                r_prod <= '0;
                r_step <= '0;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                if (i_vol[r_step]) begin
                    r_prod <= r_prod + (r_mix << r_step);
                end
                r_step <= r_step + 2'd1;
                if (r_step == 2'd3) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_prod = r_prod;
    assign o_done = r_done;

endmodule

// File: rtl/sid_mixer.sv
// SID output mixer: routes voices/ext into filter and direct sums, exchanges
// the filter sum over a valid handshake, then scales the mix by master volume.
// Optional define SID_MIXER_DC_EN adds the 6581 direct-path DC bias.
module sid_mixer
    import sid_pkg::*;
#(
    parameter int                SUM_W   = sid_pkg::SUM_W,
    parameter int                OUT_W   = sid_pkg::OUT_W,
    parameter logic signed [15:0] DC_6581 = sid_pkg::DC_6581
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    ce_1m,
    input  logic                    mode,
    input  logic signed [13:0]      voice1,
    input  logic signed [13:0]      voice2,
    input  logic signed [13:0]      voice3,
    input  logic signed [13:0]      ext_in,
    input  logic [3:0]              filt_route,
    input  logic                    voice3_off,
    input  logic [3:0]              volume,
    output logic signed [SUM_W-1:0] filter_in,
    output logic                    filter_in_valid,
    input  logic signed [SUM_W-1:0] filt_out,
    input  logic                    filt_valid,
    output logic signed [OUT_W-1:0] audio_out,
    output logic                    audio_valid,
    output logic                    overrun
);

    mix_state_t r_state, w_next;

    logic signed [13:0]      r_v1, r_v2, r_v3, r_ext;
    logic [3:0]              r_route;
    logic                    r_v3_off;
    logic [3:0]              r_vol;
    logic signed [SUM_W-1:0] r_filt_acc, r_dir_acc, r_filt_ret;
    logic signed [SUM_W-1:0] r_filter_in;
    logic                    r_fiv;
    logic signed [OUT_W-1:0] r_audio_out;
    logic                    r_audio_valid;
    logic                    r_overrun;

    logic signed [13:0]      w_src;
    logic signed [SUM_W-1:0] w_src_ext, w_dir_base;
    logic                    w_to_filt, w_mute;
    logic signed [SUM_W:0]   w_mix;
    logic signed [OUT_W-1:0] w_prod;
    logic                    w_mul_done;

`ifdef SID_MIXER_DC_EN
    logic r_mode;
    assign w_dir_base = (r_state == S1) ? (r_mode ? '0 : SUM_W'(DC_6581)) : r_dir_acc;
`else
    logic w_unused_mode;
    assign w_unused_mode = ^{mode, DC_6581};
    assign w_dir_base    = (r_state == S1) ? '0 : r_dir_acc;
`endif

    always_comb begin
        w_src     = '0;
        w_to_filt = 1'b0;
        w_mute    = 1'b0;
        case (r_state)
            S1: begin w_src = r_v1;  w_to_filt = r_route[ROUTE_V1]; end
            S2: begin w_src = r_v2;  w_to_filt = r_route[ROUTE_V2]; end
            S3: begin w_src = r_v3;  w_to_filt = r_route[ROUTE_V3]; w_mute = r_v3_off; end
            S4: begin w_src = r_ext; w_to_filt = r_route[ROUTE_EXT]; end
            default: ;
        endcase
    end

    assign w_src_ext = SUM_W'(w_src);
    assign w_mix     = (SUM_W+1)'(r_dir_acc) + (SUM_W+1)'(r_filt_ret);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (ce_1m) w_next = S1;
            S1:        w_next = S2;
            S2:        w_next = S3;
            S3:        w_next = S4;
            S4:        w_next = OFFER;
            OFFER:     w_next = WAIT_FILT;
            WAIT_FILT: if (filt_valid) w_next = MIX;
            MIX:       w_next = V0;
            V0:        w_next = V1;
            V1:        w_next = V2;
            V2:        w_next = V3;
            V3:        w_next = DONE;
            DONE:      w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_v1          <= '0;
            r_v2          <= '0;
            r_v3          <= '0;
            r_ext         <= '0;
            r_route       <= '0;
            r_v3_off      <= 1'b0;
            r_vol         <= '0;
            r_filt_acc    <= '0;
            r_dir_acc     <= '0;
            r_filt_ret    <= '0;
            r_filter_in   <= '0;
            r_fiv         <= 1'b0;
            r_audio_out   <= '0;
            r_audio_valid <= 1'b0;
            r_overrun     <= 1'b0;
`ifdef SID_MIXER_DC_EN
            r_mode        <= 1'b0;
`endif
        end else begin
            r_state       <= w_next;
            r_audio_valid <= 1'b0;
            if (ce_1m && r_state != IDLE) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                IDLE: if (ce_1m) begin
                    r_v1       <= voice1;
                    r_v2       <= voice2;
                    r_v3       <= voice3;
                    r_ext      <= ext_in;
                    r_route    <= filt_route;
                    r_v3_off   <= voice3_off;
                    r_vol      <= volume;
                    r_filt_acc <= '0;
                    r_dir_acc  <= '0;
`ifdef SID_MIXER_DC_EN
                    r_mode     <= mode;
`endif
                end
                // A muted voice 3 is dropped only when it is not routed to the filter.
                S1, S2, S3, S4: begin
                    r_filt_acc <= r_filt_acc + (w_to_filt ? w_src_ext : '0);
                    r_dir_acc  <= w_dir_base + ((w_to_filt || w_mute) ? '0 : w_src_ext);
                end
                OFFER: begin
                    r_filter_in <= r_filt_acc;
                    r_fiv       <= 1'b1;
                end
                WAIT_FILT: if (filt_valid) begin
                    r_filt_ret <= filt_out;
                    r_fiv      <= 1'b0;
                end
                DONE: if (w_mul_done) begin
                    r_audio_out   <= w_prod;
                    r_audio_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    sid_mixer_vmul #(
        .MIX_W (SUM_W + 1),
        .OUT_W (OUT_W)
    ) u_vmul (
        .clk     (clock),
        .rst_n   (reset_n),
        .i_start (r_state == MIX),
        .i_mix   (w_mix),
        .i_vol   (r_vol),
        .o_prod  (w_prod),
        .o_done  (w_mul_done)
    );

    assign filter_in       = r_filter_in;
    assign filter_in_valid = r_fiv;
    assign audio_out       = r_audio_out;
    assign audio_valid     = r_audio_valid;
    assign overrun         = r_overrun;

endmodule
